// File: rtl/axis_dest_demux_pkg.sv
// Shared types for the tdest-routed AXI4-Stream frame demultiplexer.
// Holds the frame FSM state type; the encoding is {frame, drop} so each
// state bit is directly one of the per-frame registers.
package axis_dest_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // between frames, waiting for a first beat
    ST_FWD  = 2'b10,  // inside a frame that is being forwarded
    ST_DROP = 2'b11   // inside a frame that is being consumed and discarded
  } frame_state_e;

endpackage

// File: rtl/axis_dest_demux_if.sv
// AXI4-Stream bundle carrying N lanes side by side (N=1 for the input
// stream, N=M_COUNT for the demultiplexed outputs).
//   master : drives tdata/tkeep/tvalid/tlast/tid/tdest/tuser, receives tready
//   slave  : receives the payload and valid, drives tready
interface axis_dest_demux_if #(
  parameter int N          = 1,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [N*DATA_WIDTH-1:0] tdata;
  logic [N*KEEP_WIDTH-1:0] tkeep;
  logic [N-1:0]            tvalid;
  logic [N-1:0]            tready;
  logic [N-1:0]            tlast;
  logic [N*ID_WIDTH-1:0]   tid;
  logic [N*DEST_WIDTH-1:0] tdest;
  logic [N*USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_dest_demux_out_reg.sv
// Two-entry skid register for the demultiplexer output.
// Each entry holds a one-hot valid (which port the beat belongs to) and the
// packed beat payload, so a held beat keeps its own route across frame changes.
//   clk, rst     clock, synchronous active-high reset
//   in_ready     registered input ready of a forwarding frame
//   in_valid     one-hot port of the incoming beat, zero when none
//   in_payload   packed incoming beat
//   m_ready      per-port downstream ready
//   out_valid    one-hot (or zero) output valid
//   out_payload  packed output beat
//   ready_early  next-cycle ready hint for the input ready register
module axis_demux_out_reg #(
  parameter int M_COUNT       = 4,
  parameter int PAYLOAD_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_ready,
  input  logic [M_COUNT-1:0]       in_valid,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  input  logic [M_COUNT-1:0]       m_ready,
  output logic [M_COUNT-1:0]       out_valid,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic                     ready_early
);

  logic [M_COUNT-1:0]       out_valid_q, out_valid_d;
  logic [M_COUNT-1:0]       temp_valid_q, temp_valid_d;
  logic [PAYLOAD_WIDTH-1:0] out_payload_q, out_payload_d;
  logic [PAYLOAD_WIDTH-1:0] temp_payload_q, temp_payload_d;
  logic                     out_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    out_valid_d    = out_valid_q;
    temp_valid_d   = temp_valid_q;
    out_payload_d  = out_payload_q;
    temp_payload_d = temp_payload_q;

    // One-hot valid means the held beat's own port decides whether it drains.
    out_ready   = |(out_valid_q & m_ready);
    ready_early = out_ready | (~|temp_valid_q & (~|out_valid_q | ~|in_valid));

    if (in_ready) begin
      if (out_ready || ~|out_valid_q) begin
        out_valid_d   = in_valid;
        out_payload_d = in_payload;
      end else begin
        temp_valid_d   = in_valid;
        temp_payload_d = in_payload;
      end
    end else if (out_ready) begin
      out_valid_d   = temp_valid_q;
      out_payload_d = temp_payload_q;
      temp_valid_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload registers are reset too, so every output reads 0 after reset.
      out_valid_q    <= '0;
      temp_valid_q   <= '0;
      out_payload_q  <= '0;
      temp_payload_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for state so all flops update from pre-edge values.
      out_valid_q    <= out_valid_d;
      temp_valid_q   <= temp_valid_d;
      out_payload_q  <= out_payload_d;
      temp_payload_q <= temp_payload_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_payload = out_payload_q;

endmodule

// File: rtl/axis_dest_demux.sv
// AXI4-Stream 1:M_COUNT frame demultiplexer. The tdest of a frame's first
// beat picks the output port for the whole frame; out-of-range tdest or
// drop at frame start discards the frame. Input ready is registered and the
// output goes through a two-entry skid register.
//   clk, rst     clock, synchronous active-high reset
//   s_axis       input stream (slave side, 1 lane)
//   m_axis       output streams (master side, M_COUNT lanes, payload replicated)
//   enable       allows new frames to start
//   drop         sampled at frame start, 1 discards the frame
//   frame_drop   one-cycle pulse when a frame is committed to drop
module axis_dest_demux
  import axis_dest_demux_pkg::*;
#(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                clk,
  input  logic                rst,
  axis_dest_demux_if.slave    s_axis,
  axis_dest_demux_if.master   m_axis,
  input  logic                enable,
  input  logic                drop,
  output logic                frame_drop
);

  localparam int CL_M_COUNT    = $clog2(M_COUNT);
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;
  // Range check is done wider than tdest so M_COUNT never truncates.
  localparam int CMP_WIDTH     = DEST_WIDTH + 32;

  frame_state_e              state_q, state_d;
  logic [CL_M_COUNT-1:0]     select_q, select_d;
  logic                      s_ready_q, s_ready_d;
  logic                      fwd_ready;
  logic                      ready_early;
  logic [M_COUNT-1:0]        in_valid;
  logic [M_COUNT-1:0]        out_valid;
  logic [PAYLOAD_WIDTH-1:0]  in_payload, out_payload;

  logic [KEEP_WIDTH-1:0]     keep_in, out_keep;
  logic [ID_WIDTH-1:0]       id_in, out_id;
  logic [USER_WIDTH-1:0]     user_in, out_user;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [DEST_WIDTH-1:0]     out_dest;
  logic                      out_last;

  // Frame FSM next state and input ready.
  always_comb begin
    state_d    = state_q;
    select_d   = select_q;
    frame_drop = 1'b0;

    if (s_axis.tvalid && s_ready_q && s_axis.tlast) begin
      state_d = ST_IDLE;
    end

    // Ready is low whenever idle, so a start never coincides with an accepted beat.
    if (state_q == ST_IDLE && enable && s_axis.tvalid) begin
      select_d = s_axis.tdest[CL_M_COUNT-1:0];
      if (drop || (CMP_WIDTH'(s_axis.tdest) >= CMP_WIDTH'(M_COUNT))) begin
        state_d    = ST_DROP;
        frame_drop = !rst;
      end else begin
        state_d = ST_FWD;
      end
    end

    s_ready_d = (state_d == ST_DROP) || ((state_d == ST_FWD) && ready_early);
  end

  // Only beats of a forwarded frame enter the skid register.
  always_comb begin
    fwd_ready = s_ready_q && (state_q == ST_FWD);
    in_valid  = (fwd_ready && s_axis.tvalid) ? (M_COUNT'(1) << select_q) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      select_q  <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      select_q  <= select_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_axis.tready = s_ready_q;

  assign keep_in    = (KEEP_ENABLE != 0) ? s_axis.tkeep : '1;
  assign id_in      = (ID_ENABLE != 0)   ? s_axis.tid   : '0;
  assign user_in    = (USER_ENABLE != 0) ? s_axis.tuser : '0;
  assign in_payload = {s_axis.tdata, keep_in, id_in, s_axis.tdest, user_in, s_axis.tlast};

  axis_demux_out_reg #(
    .M_COUNT       (M_COUNT),
    .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .in_ready    (fwd_ready),
    .in_valid    (in_valid),
    .in_payload  (in_payload),
    .m_ready     (m_axis.tready),
    .out_valid   (out_valid),
    .out_payload (out_payload),
    .ready_early (ready_early)
  );

  assign {out_data, out_keep, out_id, out_dest, out_user, out_last} = out_payload;

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = {M_COUNT{out_data}};
  assign m_axis.tkeep  = {M_COUNT{out_keep}};
  assign m_axis.tid    = {M_COUNT{out_id}};
  assign m_axis.tdest  = {M_COUNT{out_dest}};
  assign m_axis.tuser  = {M_COUNT{out_user}};
  assign m_axis.tlast  = {M_COUNT{out_last}};

endmodule
